nand3_selftest: RTL and testbench
=================================

NAND3_SELFTEST -- requirements
Module: nand3_selftest

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles each vector is driven before y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a self-test run.
REQ-005 abort  input  1  terminate a run in progress.
REQ-006 a, b, c  output  1 each  stimulus driven into the downstream 3-input NAND stage under test.
REQ-007 y  input  1  response returned from the NAND stage under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high while holding the results of a completed run.
REQ-010 pass  output  1  high when done is high and err_count is 0.
REQ-011 err_count  output  4  number of mismatching vectors in the last run, range 0..8.
REQ-012 fail_map  output  8  bit k set when vector k mismatched (feature-dependent, see Configuration).

Function
REQ-013 The block SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL clear err_count and fail_map, set vec=0 and settle counter=0, and go to DRIVE.
REQ-015 In DRIVE, {a,b,c} SHALL equal vec[2:0], with a as the MSB; the state SHALL stay SETTLE cycles, then go to SAMPLE.
REQ-016 In SAMPLE, {a,b,c} SHALL still equal vec; expected = ~(a&b&c), so the only expected 0 is for vec=7.
REQ-017 In SAMPLE, if y != expected, err_count SHALL increment by 1 and fail_map[vec] SHALL be set.
REQ-018 From SAMPLE, if vec<7 then vec SHALL increment and the FSM SHALL return to DRIVE; if vec=7 it SHALL go to DONE.
REQ-019 Each vector SHALL take SETTLE+1 cycles; a full run SHALL take 8*(SETTLE+1) cycles of busy=1.
REQ-020 With SETTLE=1: start sampled at edge 0 gives busy=1 in cycles 1..16 and done=1 from cycle 17.
REQ-021 busy SHALL be 1 exactly in DRIVE and SAMPLE; done SHALL be 1 exactly in DONE.
REQ-022 In IDLE and DONE, {a,b,c} SHALL be 000.
REQ-023 DONE SHALL hold done, pass, err_count and fail_map until start, or until reset_n is low.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort while busy SHALL go to IDLE at the next edge, clear err_count and fail_map, and drive abc=000.
REQ-026 abort SHALL win over a simultaneous start while busy.
REQ-027 abort in IDLE or DONE SHALL be ignored; start in the same cycle SHALL act normally.
REQ-028 err_count SHALL never exceed 8, and 4 bits SHALL hold the maximum without saturation logic.
REQ-029 y SHALL be sampled only in SAMPLE; y values in other states SHALL have no effect.

Reset
REQ-030 reset_n=0 at a rising edge SHALL force IDLE with vec=0, settle counter=0, abc=000, busy=0, done=0, pass=0, err_count=0 and fail_map=0.
REQ-031 Reset SHALL take priority over start and abort, and reset mid-run SHALL discard all partial results.
REQ-032 Outputs SHALL be fully defined in the first cycle after reset deasserts.

Configuration
REQ-033 Macro NAND3_SELFTEST_FAILMAP_EN, when defined, SHALL compile in the 8-bit fail_map register with the behaviour of REQ-017.
REQ-034 When NAND3_SELFTEST_FAILMAP_EN is undefined, fail_map SHALL be constant 8'h00 with no register, and all other behaviour SHALL be identical.

Verification
REQ-035 Correct NAND model on y, SETTLE=1, start pulse at cycle 0 -> busy cycles 1..16, done=1 from cycle 17, pass=1, err_count=0, fail_map=8'h00.
REQ-036 y stuck at 1 -> err_count=1, fail_map=8'h80, pass=0.
REQ-037 y stuck at 0 -> err_count=7, fail_map=8'h7F; with the macro undefined, fail_map=8'h00 and err_count=7.
REQ-038 abort asserted at cycle 5 -> IDLE at cycle 6 with busy=0, done=0, abc=000 and counters 0; start held during the run has no effect.
REQ-039 reset_n=0 for one cycle at cycle 9 of a run -> all outputs at reset values next cycle, and no run starts until a new start.
REQ-040 SETTLE=3 -> each abc value held 4 cycles and done asserts at cycle 33; a y glitch during DRIVE cycles has no effect on err_count.

Source files
------------

// File: rtl/nand3_selftest.sv
// nand3_selftest: sequences the eight input vectors of a 3-input NAND stage,
// compares each response y against ~(a&b&c) and records the mismatches.
//
// Parameters:
//   SETTLE     cycles each vector is driven before y is sampled (1..15)
// Ports:
//   clk        single clock, rising edge
//   reset_n    synchronous active-low reset
//   start      begin a run (from IDLE or DONE)
//   abort      cancel a run in progress
//   a, b, c    stimulus to the NAND stage, a is the MSB of the vector
//   y          response from the NAND stage
//   busy       run in progress (DRIVE or SAMPLE)
//   done       results of a completed run are held
//   pass       done with zero mismatches
//   err_count  mismatching vectors in the last run (0..8)
//   fail_map   bit k set when vector k mismatched
//
// Build option:
//   NAND3_SELFTEST_FAILMAP_EN  when defined, fail_map is a real register;
//                              otherwise it is tied to 8'h00.

module nand3_selftest #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_map
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Last settle count value before moving on to SAMPLE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] vec;
    logic [3:0] settle_cnt;

    logic       run_start;
    logic       run_abort;
    logic       expected;
    logic       mismatch;
    logic [3:0] err_next;

    // Only vector 7 (all ones) gives a low NAND output.
    assign expected  = ~(&vec);
    assign run_start = start &&
                       ((state == IDLE) || (state == DONE));
    assign run_abort = abort &&
                       ((state == DRIVE) || (state == SAMPLE));

    // y is only looked at in SAMPLE; any other state ignores it.
    assign mismatch  = (state == SAMPLE) && (y != expected);

    // At most eight increments from zero, so four bits never wrap.
    assign err_next  = err_count + {3'b000, mismatch};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        vec        <= 3'd0;
                        settle_cnt <= 4'd0;
                        {a, b, c}  <= 3'b000;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state      <= IDLE;
                        vec        <= 3'd0;
                        settle_cnt <= 4'd0;
                        {a, b, c}  <= 3'b000;
                        busy       <= 1'b0;
                        err_count  <= 4'd0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= SAMPLE;
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        vec        <= 3'd0;
                        settle_cnt <= 4'd0;
                        {a, b, c}  <= 3'b000;
                        busy       <= 1'b0;
                        err_count  <= 4'd0;
                    end else begin
                        err_count <= err_next;
                        if (vec == 3'd7) begin
                            state     <= DONE;
                            {a, b, c} <= 3'b000;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_next == 4'd0);
                        end else begin
                            state     <= DRIVE;
                            vec       <= vec + 3'd1;
                            {a, b, c} <= vec + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef NAND3_SELFTEST_FAILMAP_EN
    logic [7:0] fail_map_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fail_map_q <= 8'h00;
        end else if (run_start || run_abort) begin
            fail_map_q <= 8'h00;
        end else if (mismatch) begin
            fail_map_q[vec] <= 1'b1;
        end
    end

    assign fail_map = fail_map_q;
`else
    logic unused_ctl;

    assign unused_ctl = run_start ^ run_abort;
    assign fail_map   = 8'h00;
`endif

endmodule

// File: tb/tb_nand3_selftest.sv
// Bench for nand3_selftest: SETTLE=1 and SETTLE=3 instances driven by a
// fault-injecting NAND model, results compared with a vector-level model.

module tb_nand3_selftest;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       start1, abort1, y1;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] map1;

    logic       start3, abort3, y3;
    logic       a3, b3, c3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [7:0] map3;

    // Fault model: mode 0 = NAND with per-vector flip mask,
    // mode 1 = y stuck at 1, mode 2 = y stuck at 0.
    logic [7:0] mask1;
    logic [1:0] mode1;
    logic [7:0] mask3;
    logic       glitch3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nand3_selftest #(.SETTLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_map(map1)
    );

    nand3_selftest #(.SETTLE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .abort(abort3),
        .a(a3), .b(b3), .c(c3), .y(y3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_map(map3)
    );

    always_comb begin
        case (mode1)
            2'd0:    y1 = ~(a1 & b1 & c1) ^ mask1[{a1, b1, c1}];
            2'd1:    y1 = 1'b1;
            default: y1 = 1'b0;
        endcase
    end

    always_comb begin
        y3 = ~(a3 & b3 & c3) ^ mask3[{a3, b3, c3}] ^ glitch3;
    end

    function automatic logic [7:0] exp_map(input logic [7:0] m);
`ifdef NAND3_SELFTEST_FAILMAP_EN
        return m;
`else
        return 8'h00 & m;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then step to the first cycle after the run (cycle 17).
    task automatic run_full1(input logic [7:0] m, input logic [1:0] md);
        mask1  = m;
        mode1  = md;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (16) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start1 = 1'b1; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        mask1 = 8'h00; mode1 = 2'd0; mask3 = 8'h00; glitch3 = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy1, done1, pass1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000",
                     {busy1, done1, pass1});
        end
        checks++;
        if ({a1, b1, c1} !== 3'b000 || err1 !== 4'd0 || map1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_data abc=%b err=%0d map=%h want 000/0/00",
                     {a1, b1, c1}, err1, map1);
        end
        start1 = 1'b0;
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy1=%b busy3=%b want=0", busy1, busy3);
        end
    endtask

    task automatic test_good_run();
        mask1 = 8'h00; mode1 = 2'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL good_busy cyc=%0d busy=%b done=%b want 1/0",
                         n, busy1, done1);
            end
            checks++;
            if ({a1, b1, c1} !== 3'((n - 1) / 2)) begin
                errors++;
                $display("FAIL good_abc cyc=%0d got=%b want=%b",
                         n, {a1, b1, c1}, 3'((n - 1) / 2));
            end
            tick();
        end
        checks++;
        if ({busy1, done1, pass1} !== 3'b011) begin
            errors++;
            $display("FAIL good_done got=%b want=011", {busy1, done1, pass1});
        end
        checks++;
        if (err1 !== 4'd0 || map1 !== 8'h00 || {a1, b1, c1} !== 3'b000) begin
            errors++;
            $display("FAIL good_result err=%0d map=%h abc=%b want 0/00/000",
                     err1, map1, {a1, b1, c1});
        end
        repeat (3) tick();
        checks++;
        if ({busy1, done1, pass1} !== 3'b011) begin
            errors++;
            $display("FAIL good_hold got=%b want=011", {busy1, done1, pass1});
        end
    endtask

    task automatic test_stuck();
        run_full1(8'h00, 2'd1);
        checks++;
        if (err1 !== 4'd1 || map1 !== exp_map(8'h80) || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL stuck1 err=%0d map=%h pass=%b want 1/%h/0",
                     err1, map1, pass1, exp_map(8'h80));
        end
        run_full1(8'h00, 2'd2);
        checks++;
        if (err1 !== 4'd7 || map1 !== exp_map(8'h7F) || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL stuck0 err=%0d map=%h pass=%b want 7/%h/0",
                     err1, map1, pass1, exp_map(8'h7F));
        end
        run_full1(8'hFF, 2'd0);
        checks++;
        if (err1 !== 4'd8 || map1 !== exp_map(8'hFF) || done1 !== 1'b1) begin
            errors++;
            $display("FAIL all_bad err=%0d map=%h done=%b want 8/%h/1",
                     err1, map1, done1, exp_map(8'hFF));
        end
    endtask

    task automatic test_random_masks();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m = 8'($urandom);
            run_full1(m, 2'd0);
            checks++;
            if (err1 !== 4'($countones(m)) || map1 !== exp_map(m) ||
                pass1 !== (m == 8'h00) || done1 !== 1'b1) begin
                errors++;
                $display("FAIL rand mask=%h err=%0d map=%h pass=%b want %0d/%h/%b",
                         m, err1, map1, pass1, $countones(m), exp_map(m),
                         (m == 8'h00));
            end
        end
    endtask

    task automatic test_back_to_back();
        mask1 = 8'h00; mode1 = 2'd2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if ({busy1, done1, pass1} !== 3'b100 || err1 !== 4'd0 ||
            map1 !== 8'h00) begin
            errors++;
            $display("FAIL b2b_restart flags=%b err=%0d map=%h want 100/0/00",
                     {busy1, done1, pass1}, err1, map1);
        end
        repeat (16) tick();
        checks++;
        if (err1 !== 4'd7 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result err=%0d done=%b want 7/1", err1, done1);
        end
    endtask

    task automatic test_abort();
        mask1 = 8'h03; mode1 = 2'd0;
        start1 = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (busy1 !== 1'b1 || {a1, b1, c1} !== 3'd2 || err1 !== 4'd2 ||
            map1 !== exp_map(8'h03)) begin
            errors++;
            $display("FAIL abort_pre busy=%b abc=%b err=%0d map=%h want 1/010/2/%h",
                     busy1, {a1, b1, c1}, err1, map1, exp_map(8'h03));
        end
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        checks++;
        if ({busy1, done1, pass1} !== 3'b000 || {a1, b1, c1} !== 3'b000 ||
            err1 !== 4'd0 || map1 !== 8'h00) begin
            errors++;
            $display("FAIL abort_idle flags=%b abc=%b err=%0d map=%h want 000/000/0/00",
                     {busy1, done1, pass1}, {a1, b1, c1}, err1, map1);
        end
        repeat (3) tick();
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_stay busy=%b done=%b want 0/0", busy1, done1);
        end
    endtask

    task automatic test_idle_abort();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort busy=%b done=%b want 0/0", busy1, done1);
        end
        run_full1(8'h00, 2'd0);
        abort1 = 1'b1;
        tick();
        checks++;
        if ({busy1, done1, pass1} !== 3'b011) begin
            errors++;
            $display("FAIL done_abort flags=%b want 011", {busy1, done1, pass1});
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL done_abort_start busy=%b done=%b want 1/0",
                     busy1, done1);
        end
        repeat (16) tick();
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1) begin
            errors++;
            $display("FAIL done_abort_run done=%b pass=%b want 1/1",
                     done1, pass1);
        end
    endtask

    task automatic test_reset_midrun();
        mask1 = 8'hFF; mode1 = 2'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        checks++;
        if (busy1 !== 1'b1 || err1 !== 4'd4) begin
            errors++;
            $display("FAIL rst_pre busy=%b err=%0d want 1/4", busy1, err1);
        end
        reset_n = 1'b0;
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        reset_n = 1'b1;
        start1 = 1'b0;
        abort1 = 1'b0;
        checks++;
        if ({busy1, done1, pass1} !== 3'b000 || {a1, b1, c1} !== 3'b000 ||
            err1 !== 4'd0 || map1 !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid flags=%b abc=%b err=%0d map=%h want 000/000/0/00",
                     {busy1, done1, pass1}, {a1, b1, c1}, err1, map1);
        end
        repeat (4) tick();
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || {a1, b1, c1} !== 3'b000) begin
            errors++;
            $display("FAIL rst_norun busy=%b done=%b abc=%b want 0/0/000",
                     busy1, done1, {a1, b1, c1});
        end
    endtask

    task automatic test_settle3();
        logic [7:0] m;
        mask3 = 8'h00;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            // Corrupt y in the three drive cycles of every vector.
            glitch3 = ((n - 1) % 4) < 3;
            checks++;
            if (busy3 !== 1'b1 || {a3, b3, c3} !== 3'((n - 1) / 4)) begin
                errors++;
                $display("FAIL s3_abc cyc=%0d busy=%b abc=%b want 1/%b",
                         n, busy3, {a3, b3, c3}, 3'((n - 1) / 4));
            end
            tick();
        end
        glitch3 = 1'b0;
        checks++;
        if ({busy3, done3, pass3} !== 3'b011 || err3 !== 4'd0 ||
            map3 !== 8'h00) begin
            errors++;
            $display("FAIL s3_done flags=%b err=%0d map=%h want 011/0/00",
                     {busy3, done3, pass3}, err3, map3);
        end
        m = 8'($urandom);
        mask3 = m;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (32) tick();
        checks++;
        if (err3 !== 4'($countones(m)) || map3 !== exp_map(m) ||
            done3 !== 1'b1) begin
            errors++;
            $display("FAIL s3_rand mask=%h err=%0d map=%h want %0d/%h",
                     m, err3, map3, $countones(m), exp_map(m));
        end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_stuck();
        test_random_masks();
        test_back_to_back();
        test_abort();
        test_idle_abort();
        test_reset_midrun();
        test_settle3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
